// File: rtl/run_sequencer.sv
// run_sequencer: loads a program image into instruction memory, holds the
// core in reset through a short boot window, then times the core's run
// until it signals done or the cycle limit expires. All outputs registered.
module run_sequencer #(
    parameter int D        = 12,
    parameter int W        = 9,
    parameter int CW       = 16,
    parameter int BOOT_CYC = 2,
    parameter logic [CW-1:0] TIMEOUT = 16'd60000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          ld_valid,
    input  logic [W-1:0]  ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          im_wr_en,
    output logic [D-1:0]  im_wr_addr,
    output logic [W-1:0]  im_wr_data,
    output logic          core_reset,
    input  logic          core_done,
    output logic          busy,
    output logic          finished,
    output logic          timed_out,
    output logic [CW-1:0] cycle_count,
    output logic [D:0]    word_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_BOOT   = 3'd2,
        S_RUN    = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYC);

    state_t        state, state_nx;
    logic [D-1:0]  ptr, ptr_nx;
    logic [3:0]    bcnt, bcnt_nx;
    logic          first_run, first_run_nx;

    logic          ld_ready_nx, im_wr_en_nx, core_reset_nx;
    logic [D-1:0]  im_wr_addr_nx;
    logic [W-1:0]  im_wr_data_nx;
    logic          busy_nx, finished_nx, timed_out_nx;
    logic [CW-1:0] cycle_count_nx;
    logic [D:0]    word_count_nx;

    // ld_ready is only ever high in LOAD, so it alone qualifies a transfer.
    // The top address forces the end of the image so the pointer never wraps.
    logic xfer, last_xfer, done_hit, tmo_hit;
    assign xfer      = ld_valid & ld_ready;
    assign last_xfer = xfer & (ld_last | (ptr == {D{1'b1}}));
    // The first RUN cycle's done is ignored: the core PC is still settling.
    assign done_hit  = (state == S_RUN) & ~first_run & core_done;
    assign tmo_hit   = (state == S_RUN) & (cycle_count == TIMEOUT);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state selection; done has priority over timeout.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_LOAD;
            S_LOAD:   if (last_xfer) state_nx = S_BOOT;
            S_BOOT:   if (bcnt == 4'd1) state_nx = S_RUN;
            S_RUN:    if (done_hit || tmo_hit) state_nx = S_FINISH;
            S_FINISH: if (start) state_nx = S_LOAD;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath. Status flags are
    // decoded from the next state so they line up with the state itself.
    always_comb begin
        ptr_nx         = ptr;
        bcnt_nx        = bcnt;
        first_run_nx   = first_run;
        im_wr_en_nx    = 1'b0;
        im_wr_addr_nx  = im_wr_addr;
        im_wr_data_nx  = im_wr_data;
        timed_out_nx   = timed_out;
        cycle_count_nx = cycle_count;
        word_count_nx  = word_count;
        ld_ready_nx    = (state_nx == S_LOAD);
        busy_nx        = (state_nx == S_LOAD) || (state_nx == S_BOOT) || (state_nx == S_RUN);
        finished_nx    = (state_nx == S_FINISH);
        core_reset_nx  = (state_nx != S_RUN);
        case (state)
            S_IDLE: begin
                ptr_nx         = '0;
                timed_out_nx   = 1'b0;
                cycle_count_nx = '0;
                word_count_nx  = '0;
            end
            S_LOAD: begin
                bcnt_nx = BOOT_INIT;
                if (xfer) begin
                    im_wr_en_nx   = 1'b1;
                    im_wr_addr_nx = ptr;
                    im_wr_data_nx = ld_data;
                    ptr_nx        = ptr + D'(1);
                    word_count_nx = word_count + (D+1)'(1);
                end
            end
            S_BOOT: begin
                bcnt_nx      = bcnt - 4'd1;
                first_run_nx = 1'b1;
            end
            S_RUN: begin
                first_run_nx = 1'b0;
                if (done_hit)
                    timed_out_nx = 1'b0;
                else if (tmo_hit)
                    timed_out_nx = 1'b1;
                else if (cycle_count != {CW{1'b1}})
                    cycle_count_nx = cycle_count + CW'(1);
            end
            S_FINISH: begin
                if (start) begin
                    ptr_nx         = '0;
                    timed_out_nx   = 1'b0;
                    cycle_count_nx = '0;
                    word_count_nx  = '0;
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr         <= '0;
            bcnt        <= '0;
            first_run   <= 1'b1;
            ld_ready    <= 1'b0;
            im_wr_en    <= 1'b0;
            im_wr_addr  <= '0;
            im_wr_data  <= '0;
            core_reset  <= 1'b1;
            busy        <= 1'b0;
            finished    <= 1'b0;
            timed_out   <= 1'b0;
            cycle_count <= '0;
            word_count  <= '0;
        end else begin
            ptr         <= ptr_nx;
            bcnt        <= bcnt_nx;
            first_run   <= first_run_nx;
            ld_ready    <= ld_ready_nx;
            im_wr_en    <= im_wr_en_nx;
            im_wr_addr  <= im_wr_addr_nx;
            im_wr_data  <= im_wr_data_nx;
            core_reset  <= core_reset_nx;
            busy        <= busy_nx;
            finished    <= finished_nx;
            timed_out   <= timed_out_nx;
            cycle_count <= cycle_count_nx;
            word_count  <= word_count_nx;
        end
    end

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: instance A uses default parameters, instance B
// uses D=3 and TIMEOUT=50. A phase-level model predicts every output each
// cycle; directed scenarios add literal checks that pin the model.
module tb_run_sequencer;

    localparam int P_IDLE = 0, P_LOAD = 1, P_BOOT = 2, P_RUN = 3, P_FIN = 4;
    localparam int BOOT_CYC = 2;

    typedef struct {
        int ph;
        int age;
        int ptr;
        int wc;
        int cc;
        bit to;
        bit we;
        int wa;
        int wd;
    } mdl_t;

    logic clk, rst;

    logic        a_start, a_vld, a_last, a_rdy, a_we, a_cr, a_done, a_busy, a_fin, a_to;
    logic [8:0]  a_data, a_wd;
    logic [11:0] a_wa;
    logic [15:0] a_cc;
    logic [12:0] a_wc;

    logic        b_start, b_vld, b_last, b_rdy, b_we, b_cr, b_done, b_busy, b_fin, b_to;
    logic [8:0]  b_data, b_wd;
    logic [2:0]  b_wa;
    logic [15:0] b_cc;
    logic [3:0]  b_wc;

    int n_chk = 0, n_fail = 0;
    mdl_t m [2];
    logic [8:0] img [5];
    int log_a [$], log_d [$];
    int a_run, b_run, a_dat, b_dat, a_bl, b_bl;
    bit a_den, b_den;

    run_sequencer u_a (
        .clk(clk), .reset(rst), .start(a_start), .ld_valid(a_vld), .ld_data(a_data),
        .ld_last(a_last), .ld_ready(a_rdy), .im_wr_en(a_we), .im_wr_addr(a_wa),
        .im_wr_data(a_wd), .core_reset(a_cr), .core_done(a_done), .busy(a_busy),
        .finished(a_fin), .timed_out(a_to), .cycle_count(a_cc), .word_count(a_wc)
    );

    run_sequencer #(.D(3), .TIMEOUT(16'd50)) u_b (
        .clk(clk), .reset(rst), .start(b_start), .ld_valid(b_vld), .ld_data(b_data),
        .ld_last(b_last), .ld_ready(b_rdy), .im_wr_en(b_we), .im_wr_addr(b_wa),
        .im_wr_data(b_wd), .core_reset(b_cr), .core_done(b_done), .busy(b_busy),
        .finished(b_fin), .timed_out(b_to), .cycle_count(b_cc), .word_count(b_wc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stand-ins: count cycles out of reset, raise done from cycle *_dat.
    always @(posedge clk) begin
        a_run <= a_cr ? 0 : a_run + 1;
        b_run <= b_cr ? 0 : b_run + 1;
    end
    assign a_done = !a_cr && a_den && (a_run >= a_dat);
    assign b_done = !b_cr && b_den && (b_run >= b_dat);

    function automatic mdl_t mreset();
        mdl_t r;
        r.ph = P_IDLE; r.age = 0; r.ptr = 0; r.wc = 0; r.cc = 0;
        r.to = 0; r.we = 0; r.wa = 0; r.wd = 0;
        return r;
    endfunction

    // One clock of the sequencer, phrased as phases and their ages.
    function automatic mdl_t step(mdl_t m0, bit st, bit v, bit last, int dat, bit done,
                                  int d, int tmo);
        mdl_t n = m0;
        n.we  = 0;
        n.age = m0.age + 1;
        case (m0.ph)
            P_IDLE, P_FIN: begin
                if (m0.ph == P_IDLE || st) begin
                    n.wc = 0; n.cc = 0; n.to = 0; n.ptr = 0;
                end
                if (st) begin n.ph = P_LOAD; n.age = 0; end
            end
            P_LOAD: if (v) begin
                n.we = 1; n.wa = m0.ptr; n.wd = dat;
                n.ptr = m0.ptr + 1; n.wc = m0.wc + 1;
                if (last || m0.ptr == (1 << d) - 1) begin n.ph = P_BOOT; n.age = 0; end
            end
            P_BOOT: if (m0.age == BOOT_CYC - 1) begin n.ph = P_RUN; n.age = 0; end
            P_RUN: begin
                if (m0.age >= 1 && done) n.ph = P_FIN;
                else if (m0.cc == tmo) begin n.ph = P_FIN; n.to = 1; end
                else if (m0.cc < 65535) n.cc = m0.cc + 1;
            end
            default: n = mreset();
        endcase
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m[0] <= mreset();
            m[1] <= mreset();
        end else begin
            m[0] <= step(m[0], a_start, a_vld, a_last, int'(a_data), a_done, 12, 60000);
            m[1] <= step(m[1], b_start, b_vld, b_last, int'(b_data), b_done, 3, 50);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input string p, input mdl_t e, input logic rdy, input logic we,
                       input logic [31:0] wa, input logic [31:0] wd, input logic cr,
                       input logic busy, input logic fin, input logic to,
                       input logic [31:0] cc, input logic [31:0] wc);
        chk({p, "ld_ready"}, 32'(rdy), 32'(e.ph == P_LOAD));
        chk({p, "im_wr_en"}, 32'(we), 32'(e.we));
        if (e.we) begin
            chk({p, "im_wr_addr"}, wa, e.wa);
            chk({p, "im_wr_data"}, wd, e.wd);
        end
        chk({p, "core_reset"}, 32'(cr), 32'(e.ph != P_RUN));
        chk({p, "busy"}, 32'(busy), 32'(e.ph == P_LOAD || e.ph == P_BOOT || e.ph == P_RUN));
        chk({p, "finished"}, 32'(fin), 32'(e.ph == P_FIN));
        chk({p, "timed_out"}, 32'(to), 32'(e.to));
        chk({p, "cycle_count"}, cc, e.cc);
        chk({p, "word_count"}, wc, e.wc);
    endtask

    // Compare process: every cycle, both instances, against the model.
    always @(negedge clk) begin
        if (!rst) begin
            cmp("A.", m[0], a_rdy, a_we, 32'(a_wa), 32'(a_wd), a_cr, a_busy, a_fin, a_to,
                32'(a_cc), 32'(a_wc));
            cmp("B.", m[1], b_rdy, b_we, 32'(b_wa), 32'(b_wd), b_cr, b_busy, b_fin, b_to,
                32'(b_cc), 32'(b_wc));
        end
    end

    // Write log and boot-length monitor (cycles with core held, not loading).
    always @(negedge clk) begin
        if (!rst && a_we) begin log_a.push_back(int'(a_wa)); log_d.push_back(int'(a_wd)); end
        if (!rst && b_we) begin log_a.push_back(int'(b_wa)); log_d.push_back(int'(b_wd)); end
        if (a_rdy) a_bl <= 0; else if (a_busy && a_cr) a_bl <= a_bl + 1;
        if (b_rdy) b_bl <= 0; else if (b_busy && b_cr) b_bl <= b_bl + 1;
    end

    function automatic int word(input int sel, input int k);
        return (sel == 0) ? int'(img[k % 5]) : (k * 37 + 11) % 512;
    endfunction

    task automatic drive(input int i, input logic v, input int d, input logic l);
        if (i == 0) begin a_vld = v; a_data = 9'(d); a_last = l; end
        else        begin b_vld = v; b_data = 9'(d); b_last = l; end
    endtask

    task automatic pulse(input int i);
        if (i == 0) a_start = 1'b1; else b_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0; b_start = 1'b0;
    endtask

    task automatic load(input int i, input int n, input bit gap, input bit lst, input int sel);
        for (int k = 0; k < n; k++) begin
            drive(i, 1'b1, word(sel, k), lst && (k == n - 1));
            @(negedge clk);
            if (gap) begin drive(i, 1'b0, 0, 1'b0); @(negedge clk); end
        end
        drive(i, 1'b0, 0, 1'b0);
    endtask

    task automatic wait_run(input int i, input int lim);
        int k = 0;
        while (((i == 0) ? a_cr : b_cr) && k < lim) begin @(negedge clk); k++; end
        chk("wait_release", 32'((i == 0) ? a_cr : b_cr), 32'd0);
    endtask

    task automatic wait_fin(input int i, input int lim);
        int k = 0;
        while (!((i == 0) ? a_fin : b_fin) && k < lim) begin @(negedge clk); k++; end
        chk("wait_finish", 32'((i == 0) ? a_fin : b_fin), 32'd1);
    endtask

    task automatic check_log(input string nm, input int n, input int sel);
        chk({nm, "_nwrites"}, 32'(log_a.size()), 32'(n));
        for (int k = 0; k < n && k < log_a.size(); k++) begin
            chk($sformatf("%s_addr%0d", nm, k), 32'(log_a[k]), 32'(k));
            chk($sformatf("%s_data%0d", nm, k), 32'(log_d[k]), 32'(word(sel, k)));
        end
        log_a.delete(); log_d.delete();
    endtask

    initial begin
        img = '{9'h1C8, 9'h001, 9'h0F0, 9'h1FF, 9'h055};
        rst = 1'b1;
        a_start = 0; a_vld = 0; a_data = 0; a_last = 0; a_den = 0; a_dat = 0;
        b_start = 0; b_vld = 0; b_data = 0; b_last = 0; b_den = 0; b_dat = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_core_reset", 32'(a_cr), 32'd1);
        chk("idle_busy", 32'(a_busy), 32'd0);
        chk("idle_word_count", 32'(a_wc), 32'd0);

        // Back-to-back load, core finishes 300 cycles after release.
        a_den = 1; a_dat = 300;
        pulse(0);
        load(0, 5, 1'b0, 1'b1, 0);
        wait_run(0, 20);
        chk("b2b_word_count", 32'(a_wc), 32'd5);
        chk("b2b_boot_len", 32'(a_bl), 32'd2);
        check_log("b2b", 5, 0);
        wait_fin(0, 1000);
        chk("done_cycle_count", 32'(a_cc), 32'd300);
        chk("done_timed_out", 32'(a_to), 32'd0);
        chk("done_core_reset", 32'(a_cr), 32'd1);

        // Stalled load from FINISH; done already high in the first RUN cycle.
        a_dat = 0;
        pulse(0);
        load(0, 5, 1'b1, 1'b1, 0);
        wait_run(0, 20);
        chk("stall_word_count", 32'(a_wc), 32'd5);
        chk("stall_boot_len", 32'(a_bl), 32'd2);
        check_log("stall", 5, 0);
        wait_fin(0, 50);
        chk("first_run_ignored_cc", 32'(a_cc), 32'd1);

        // Timeout with no done, then done coincident with the timeout.
        pulse(1);
        load(1, 5, 1'b0, 1'b1, 0);
        wait_fin(1, 200);
        chk("tmo_timed_out", 32'(b_to), 32'd1);
        chk("tmo_cycle_count", 32'(b_cc), 32'd50);
        check_log("tmo", 5, 0);
        b_den = 1; b_dat = 50;
        pulse(1);
        load(1, 3, 1'b0, 1'b1, 0);
        wait_fin(1, 200);
        chk("tie_timed_out", 32'(b_to), 32'd0);
        chk("tie_cycle_count", 32'(b_cc), 32'd50);
        log_a.delete(); log_d.delete();

        // Image overruns the 8-word memory; start during RUN is ignored.
        b_den = 0;
        pulse(1);
        load(1, 10, 1'b0, 1'b0, 1);
        wait_run(1, 20);
        chk("ovf_word_count", 32'(b_wc), 32'd8);
        check_log("ovf", 8, 1);
        repeat (5) @(negedge clk);
        pulse(1);
        wait_fin(1, 200);
        chk("ovf_cycle_count", 32'(b_cc), 32'd50);
        pulse(1);
        chk("rerun_word_count", 32'(b_wc), 32'd0);
        chk("rerun_cycle_count", 32'(b_cc), 32'd0);
        chk("rerun_finished", 32'(b_fin), 32'd0);
        chk("rerun_ld_ready", 32'(b_rdy), 32'd1);
        load(1, 2, 1'b0, 1'b1, 0);
        wait_fin(1, 200);
        log_a.delete(); log_d.delete();

        // Reset in the middle of a load.
        pulse(0);
        load(0, 2, 1'b0, 1'b0, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_core_reset", 32'(a_cr), 32'd1);
        chk("rst_ld_ready", 32'(a_rdy), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_finished", 32'(a_fin), 32'd0);
        chk("rst_cycle_count", 32'(a_cc), 32'd0);
        chk("rst_word_count", 32'(a_wc), 32'd0);
        chk("rst_im_wr_en", 32'(a_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", 32'(a_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Upstream control stage for the processor core top level.
- Accepts a program image as a stream of 9-bit machine-code words over a valid/ready handshake and writes it into the instruction memory write port.
- Holds the core in reset during load, then releases it and counts execution cycles until the core raises done or a timeout expires.
- Reports status (busy, finished, timeout, cycle count, word count) to the bench or host.

Parameters:
- D, 12, instruction address width; matches the core program counter width.
- W, 9, machine-code word width.
- CW, 16, cycle counter width.
- BOOT_CYC, 2, number of cycles core_reset stays high after load, before release; legal range 1..15.
- TIMEOUT, 16'd60000, RUN cycle limit; must be < 2^CW.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin load+run; honoured only in IDLE and FINISH.
- ld_valid  in  1  load word valid.
- ld_data  in  W  load word (machine code).
- ld_last  in  1  marks final word of the image; qualified by ld_valid.
- ld_ready  out  1  sequencer can accept a load word.
- im_wr_en  out  1  instruction memory write strobe.
- im_wr_addr  out  D  instruction memory write address.
- im_wr_data  out  W  instruction memory write data.
- core_reset  out  1  drives the core's reset input.
- core_done  in  1  core's done flag (combinational in the core).
- busy  out  1  high in LOAD, BOOT and RUN.
- finished  out  1  high in FINISH.
- timed_out  out  1  run ended by TIMEOUT, not by core_done.
- cycle_count  out  CW  RUN cycles elapsed.
- word_count  out  D+1  words written in the current load.

Behaviour:
- **Reset** (async, any state): state=IDLE. core_reset=1. ld_ready=0, im_wr_en=0, im_wr_addr=0, im_wr_data=0. busy=0, finished=0, timed_out=0. cycle_count=0, word_count=0. A reset mid-LOAD or mid-RUN abandons the operation; partially written memory is not cleared.
- **Registered outputs:** all outputs are registered. core_reset=1 in every state except RUN.
- **IDLE:**
  - start=1 -> LOAD next cycle.
  - Clear cycle_count, word_count, finished and timed_out.
  - Write pointer = 0.
- **LOAD:**
  - ld_ready=1 registered, asserted from the first LOAD cycle.
  - A transfer occurs when ld_valid & ld_ready.
  - One cycle after a transfer: im_wr_en=1, im_wr_addr=ptr, im_wr_data=ld_data.
  - On each transfer: ptr+1 and word_count+1.
  - One word per cycle is accepted back-to-back.
  - Transfer with ld_last=1, or transfer at ptr=2^D-1 (forced last, no wrap) -> BOOT. ld_ready=0 from the next cycle; the final write strobe still issues.
  - ld_valid=0 -> no write; remain in LOAD indefinitely.
- **BOOT:**
  - core_reset=1, ld_ready=0, im_wr_en=0 after the final write.
  - Down-counter loads BOOT_CYC on entry.
  - Counter reaches 0 -> RUN. BOOT lasts exactly BOOT_CYC cycles.
- **RUN:**
  - core_reset=0 starting the first RUN cycle.
  - core_done is sampled each clock; it is ignored in the first RUN cycle because the core PC may still be settling.
  - Each RUN cycle without a stop condition: cycle_count+1, saturating at 2^CW-1.
  - Sampled core_done=1 -> FINISH. cycle_count freezes at the number of RUN cycles preceding that edge.
  - cycle_count==TIMEOUT -> FINISH with timed_out=1.
  - core_done and timeout in the same cycle: done wins, timed_out=0.
- **FINISH:**
  - finished=1, busy=0, core_reset=1 (core frozen).
  - cycle_count and word_count hold.
  - start -> LOAD. Clear finished, timed_out and counters; ptr=0.
- **start handling:** start in LOAD, BOOT or RUN is ignored. ld_valid outside LOAD is ignored (ld_ready=0).
- **ld_last handling:** ld_last without ld_valid has no effect.

Test Plan:
- **Reset defaults:** assert reset mid-cycle with clk running -> immediately core_reset=1, ld_ready=0, busy=0, finished=0, cycle_count=0.
- **Back-to-back load and boot:** start, stream 5 words 9'h1C8,9'h001,9'h0F0,9'h1FF,9'h055 with ld_valid held and last on word 5.
  - Required: im_wr_en pulses 5 consecutive cycles at addr 0..4 with matching data.
  - Required: word_count=5, BOOT lasts 2 cycles, then core_reset=0.
- **Stalled load:** same image with ld_valid low every other cycle -> identical memory writes at addr 0..4, writes only on transfer+1 cycles, word_count=5.
- **Normal completion:** core model raises core_done 300 cycles after release -> FINISH with cycle_count=300, finished=1, timed_out=0, core_reset=1.
- **Timeout:** TIMEOUT=50, core_done never rises -> FINISH with timed_out=1, cycle_count=50. Then, with core_done rising at cycle 50 and TIMEOUT=50 -> timed_out=0.
- **Overflow and rerun:** D=3, stream 10 words with no ld_last -> 8 writes (addr 0..7), then BOOT, word_count=8. Then start in FINISH -> new LOAD with counters cleared. start pulsed during RUN -> ignored.
